// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - fta 128-bit bus request/response types
package fta_bus_pkg;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] dat;
        fta_tranid_t  tid;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         rty;
        logic [127:0] dat;
        fta_tranid_t  tid;
    } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// rtl/rf80386_pkg.sv - rf80386 shared types: instruction fetch FSM and code line entry
package rf80386_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        RETRY = 2'd3
    } e_ifetch_state;

    typedef struct packed {
        logic [27:0]  tag;
        logic         valid;
        logic [127:0] data;
    } ifetch_line_t;

    // Transaction ids cycle 1..15; 0 is never issued.
    function automatic logic [3:0] next_tranid(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

endpackage

// File: rtl/rf80386_bundle_align.sv
// rtl/rf80386_bundle_align.sv - byte shifter selecting 16 bytes from a two-line window
module rf80386_bundle_align (
    input  logic [255:0] line_pair,
    input  logic [3:0]   offset,
    output logic [127:0] bundle
);

    assign bundle = 128'(line_pair >> {offset, 3'b000});

endmodule

// File: rtl/rf80386_ibundle_fetch.sv
// rtl/rf80386_ibundle_fetch.sv - two-line instruction bundle prefetcher with fta bus fill port
module rf80386_ibundle_fetch
    import fta_bus_pkg::*;
    import rf80386_pkg::*;
#(
    parameter logic [5:0] CORENO = 6'd1,
    parameter logic [2:0] CID    = 3'd2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          csip,
    input  logic                 inv_i,
    output logic [127:0]         ibundle,
    output logic                 ihit,
    output fta_cmd_request128_t  ftam_req,
    input  fta_cmd_response128_t ftam_resp
);

    e_ifetch_state state, state_nxt;
    ifetch_line_t  ent [2];
    logic [27:0]   req_tag;
    logic          victim;
    logic [3:0]    tranid;
    logic          stale;

    logic [27:0]   tag_l0, tag_l1;
    logic          e0_l0, e1_l0, e0_l1, e1_l1;
    logic          hit_l0, hit_l1;
    logic [127:0]  data_l0, data_l1;
    logic [27:0]   miss_tag;
    logic          miss_victim;
    logic          bus_active, resp_match;
    logic          capture, fill_done;

    assign tag_l0 = csip[31:4];
    assign tag_l1 = tag_l0 + 28'd1;

    assign e0_l0  = ent[0].valid && (ent[0].tag == tag_l0);
    assign e1_l0  = ent[1].valid && (ent[1].tag == tag_l0);
    assign e0_l1  = ent[0].valid && (ent[0].tag == tag_l1);
    assign e1_l1  = ent[1].valid && (ent[1].tag == tag_l1);
    assign hit_l0 = e0_l0 || e1_l0;
    assign hit_l1 = e0_l1 || e1_l1;
    assign ihit   = hit_l0 && hit_l1;

    assign data_l0 = e0_l0 ? ent[0].data : ent[1].data;
    assign data_l1 = e0_l1 ? ent[0].data : ent[1].data;

    rf80386_bundle_align u_align (
        .line_pair ({data_l1, data_l0}),
        .offset    (csip[3:0]),
        .bundle    (ibundle)
    );

    // L0 first; the victim is whichever entry is not holding the other needed line.
    always_comb begin
        miss_tag    = tag_l0;
        miss_victim = 1'b0;
        if (!hit_l0) begin
            miss_tag = tag_l0;
            if (e0_l1)      miss_victim = 1'b1;
            else            miss_victim = 1'b0;
        end else begin
            miss_tag = tag_l1;
            if (e0_l0)      miss_victim = 1'b1;
            else if (e1_l0) miss_victim = 1'b0;
            else            miss_victim = 1'b1;
        end
    end

    assign bus_active = (state == REQ) || (state == WAIT);
    assign resp_match = (ftam_resp.tid == ftam_req.tid);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (!ihit && !inv_i) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (resp_match && ftam_resp.ack) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end else if (resp_match && ftam_resp.rty) begin
                    state_nxt = RETRY;
                end
            end
            RETRY: state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ftam_req             = '0;
        ftam_req.cyc         = bus_active;
        ftam_req.stb         = bus_active;
        ftam_req.we          = 1'b0;
        ftam_req.sel         = bus_active ? 16'hFFFF : 16'h0000;
        ftam_req.adr         = {req_tag, 4'h0};
        ftam_req.tid.core    = CORENO;
        ftam_req.tid.channel = CID;
        ftam_req.tid.tranid  = tranid;
    end

    // A fill that saw inv_i while in flight still completes on the bus but is never marked valid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            req_tag <= '0;
            victim  <= 1'b0;
            tranid  <= 4'd1;
            stale   <= 1'b0;
            ent[0]  <= '0;
            ent[1]  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                req_tag <= miss_tag;
                victim  <= miss_victim;
                stale   <= 1'b0;
            end else if (inv_i && state != IDLE) begin
                stale <= 1'b1;
            end
            if (inv_i) begin
                ent[0].valid <= 1'b0;
                ent[1].valid <= 1'b0;
            end
            if (fill_done) begin
                tranid <= next_tranid(tranid);
                if (!stale && !inv_i) begin
                    ent[victim] <= '{tag: req_tag, valid: 1'b1, data: ftam_resp.dat};
                end
            end
        end
    end

endmodule

// File: tb/tb_rf80386_ibundle_fetch.sv
// tb/tb_rf80386_ibundle_fetch.sv - self-checking bench for rf80386_ibundle_fetch
module tb_rf80386_ibundle_fetch;
    import fta_bus_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [31:0]          csip;
    logic                 inv_i;
    logic [127:0]         ibundle;
    logic                 ihit;
    fta_cmd_request128_t  ftam_req;
    fta_cmd_response128_t ftam_resp;

    always #5 clk_i = ~clk_i;

    rf80386_ibundle_fetch #(.CORENO(6'd1), .CID(3'd2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .csip      (csip),
        .inv_i     (inv_i),
        .ibundle   (ibundle),
        .ihit      (ihit),
        .ftam_req  (ftam_req),
        .ftam_resp (ftam_resp)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  tid;
    } req_t;

    req_t       exp_q[$];
    logic [3:0] exp_tid;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle_ctr = 0;
    int         ack_cycle = 0;
    int         resp_delay;
    bit         rty_once, stray_once, after_rty, done;
    int         cnt, gap;

    always @(posedge clk_i) cycle_ctr <= cycle_ctr + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_data(input logic [27:0] t);
        return {t ^ 28'h5A5A5A5, 4'h3, ~t, 4'hC, t + 28'h1234567, 4'h9, t, 4'hF};
    endfunction

    function automatic logic [127:0] exp_bundle(input logic [31:0] a);
        logic [27:0]  t0, t1;
        logic [255:0] pair;
        logic [127:0] r;
        int           off;
        t0   = a[31:4];
        t1   = t0 + 28'd1;
        pair = {line_data(t1), line_data(t0)};
        off  = int'(a[3:0]);
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = pair[(off + i)*8 +: 8];
        return r;
    endfunction

    task automatic push_new(input logic [31:0] a);
        exp_q.push_back('{adr: a, tid: exp_tid});
        exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
    endtask

    task automatic push_retry(input logic [31:0] a);
        exp_q.push_back('{adr: a, tid: exp_tid});
        exp_q.push_back('{adr: a, tid: exp_tid});
        exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
    endtask

    task automatic goto(input logic [31:0] a);
        @(negedge clk_i);
        csip = a;
        #1;
    endtask

    task automatic wait_ihit(input string tag);
        int n = 0;
        while (!ihit && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, ihit, 1'b1);
    endtask

    task automatic wait_cyc(input string tag);
        int n = 0;
        while (!ftam_req.cyc && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, ftam_req.cyc, 1'b1);
    endtask

    // Bus responder: answers resp_delay samples after a request appears, with optional rty/stray.
    initial begin
        req_t e;
        ftam_resp = '0;
        cnt = 0; gap = 0; done = 0; after_rty = 0;
        forever begin
            @(posedge clk_i);
            #1;
            ftam_resp = '0;
            if (!ftam_req.cyc) begin
                cnt = 0;
                gap++;
            end else begin
                if (cnt == 0) begin
                    done = 0;
                    if (after_rty) chk("rty_gap", gap, 1);
                    after_rty = 0;
                    chk("sb_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("req_adr", ftam_req.adr, e.adr);
                        chk("req_tid", ftam_req.tid.tranid, e.tid);
                    end
                    chk("req_we", ftam_req.we, 1'b0);
                    chk("req_sel", ftam_req.sel, 16'hFFFF);
                end
                gap = 0;
                if (cnt >= resp_delay && !done) begin
                    ftam_resp.tid = ftam_req.tid;
                    ftam_resp.dat = line_data(ftam_req.adr[31:4]);
                    if (rty_once) begin
                        ftam_resp.rty = 1'b1;
                        rty_once  = 0;
                        after_rty = 1;
                        done      = 1;
                    end else if (stray_once) begin
                        ftam_resp.ack        = 1'b1;
                        ftam_resp.tid.tranid = ~ftam_req.tid.tranid;
                        ftam_resp.dat        = ~line_data(ftam_req.adr[31:4]);
                        stray_once = 0;
                    end else begin
                        ftam_resp.ack = 1'b1;
                        done      = 1;
                        ack_cycle = cycle_ctr;
                    end
                end
                cnt++;
            end
        end
    end

    initial begin
        int n_req, n_hit;
        logic [127:0] hi_line, lo_line;
        rst_i = 1'b0; inv_i = 1'b0; csip = 32'hFFFF0000;
        resp_delay = 1; rty_once = 0; stray_once = 0;
        exp_tid = 4'd1;
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", ftam_req.cyc, 1'b0);
        chk("rst_stb", ftam_req.stb, 1'b0);
        chk("rst_we", ftam_req.we, 1'b0);
        chk("rst_sel", ftam_req.sel, 16'h0);
        chk("rst_adr", ftam_req.adr, 32'h0);
        chk("rst_core", ftam_req.tid.core, 6'd1);
        chk("rst_channel", ftam_req.tid.channel, 3'd2);
        chk("rst_tranid", ftam_req.tid.tranid, 4'd1);
        chk("rst_ihit", ihit, 1'b0);

        // Cold start: cycle of reset release counts as cycle 1.
        push_new(32'hFFFF0000);
        push_new(32'hFFFF0010);
        rst_i = 1'b1;
        n_req = 0; n_hit = 0;
        for (int i = 1; i <= 40 && n_hit == 0; i++) begin
            @(negedge clk_i);
            if (ftam_req.cyc && n_req == 0) n_req = i + 1;
            if (ihit) n_hit = i + 1;
        end
        chk("cold_req_lat", n_req, 2);
        chk("cold_hit_lat", n_hit, 7);
        lo_line = line_data(28'hFFFF000);
        chk("cold_byte0", ibundle[7:0], lo_line[7:0]);
        chk("cold_bundle", ibundle, exp_bundle(32'hFFFF0000));

        push_new(32'h10000000);
        push_new(32'h10000010);
        goto(32'h10000000);
        wait_ihit("l10_fill");
        goto(32'h1000000B);
        chk("hit_0lat", ihit, 1'b1);
        lo_line = line_data(28'h1000000);
        hi_line = line_data(28'h1000001);
        chk("hit_b_lo", ibundle[7:0], lo_line[95:88]);
        chk("hit_b_hi", ibundle[127:120], hi_line[87:80]);
        chk("hit_bundle", ibundle, exp_bundle(32'h1000000B));

        goto(32'h1000000F);
        chk("seq_f_hit", ihit, 1'b1);
        chk("seq_f_bundle", ibundle, exp_bundle(32'h1000000F));
        push_new(32'h10000020);
        goto(32'h10000010);
        chk("seq_drop", ihit, 1'b0);
        wait_ihit("seq_fill");
        chk("seq_ack_to_hit", cycle_ctr - ack_cycle, 1);
        chk("seq_bundle", ibundle, exp_bundle(32'h10000010));
        push_new(32'h10000000);
        goto(32'h10000000);
        chk("seq_evicted_e0", ihit, 1'b0);
        wait_ihit("seq_refill");
        chk("seq_refill_bundle", ibundle, exp_bundle(32'h10000000));

        push_new(32'hFFFFFFF0);
        push_new(32'h00000000);
        goto(32'hFFFFFFF8);
        wait_ihit("wrap_fill");
        hi_line = line_data(28'hFFFFFFF);
        lo_line = line_data(28'h0000000);
        chk("wrap_low64", ibundle[63:0], hi_line[127:64]);
        chk("wrap_high64", ibundle[127:64], lo_line[63:0]);

        rty_once = 1; stray_once = 1;
        push_retry(32'h20000000);
        push_new(32'h20000010);
        goto(32'h20000000);
        wait_ihit("rty_fill");
        chk("rty_bundle", ibundle, exp_bundle(32'h20000004 & 32'hFFFFFFF0));

        resp_delay = 4;
        push_new(32'h30000000);
        push_new(32'h30000000);
        push_new(32'h30000010);
        goto(32'h30000000);
        wait_cyc("inv_req");
        @(negedge clk_i);
        inv_i = 1'b1;
        @(negedge clk_i);
        inv_i = 1'b0;
        resp_delay = 1;
        for (int i = 0; i < 4; i++) begin
            chk("inv_ihit_low", ihit, 1'b0);
            @(negedge clk_i);
        end
        wait_ihit("inv_refill");
        chk("inv_bundle", ibundle, exp_bundle(32'h30000000));

        push_new(32'h30000000);
        push_new(32'h30000010);
        @(negedge clk_i);
        inv_i = 1'b1;
        @(negedge clk_i);
        inv_i = 1'b0;
        #1;
        chk("inv_clear", ihit, 1'b0);
        wait_ihit("inv_clear_refill");

        push_new(32'h50000000);
        push_new(32'h50000010);
        goto(32'h50000007);
        wait_ihit("tid_wrap_fill");
        chk("tid_wrap_bundle", ibundle, exp_bundle(32'h50000007));

        resp_delay = 20;
        push_new(32'h60000000);
        goto(32'h60000000);
        wait_cyc("rstmid_req");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rstmid_cyc", ftam_req.cyc, 1'b0);
        chk("rstmid_stb", ftam_req.stb, 1'b0);
        chk("rstmid_tranid", ftam_req.tid.tranid, 4'd1);
        resp_delay = 1;
        exp_tid = 4'd1;
        push_new(32'h60000000);
        push_new(32'h60000010);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        wait_ihit("rstmid_refill");
        chk("rstmid_bundle", ibundle, exp_bundle(32'h60000000));

        repeat (3) @(negedge clk_i);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
